cd_host_if: RTL
===============

Name: cd_host_if

Overview:
- Host-side register interface of the CD block on SCU A-bus chip-select 2: HIRQ, HIRQMASK and NUM_CR command/response registers.
- Write-edge detection, a command handshake toward the CD controller, response loading, a response timeout and a registered interrupt output.
- Sits between SCU A-bus signals (AA/ADO/ACS2_N/AWRx_N) and the CD controller core; replaces the fixed inline register stub in the Saturn top level.

Parameters:
- NUM_CR, 4, number of 16-bit command/response registers (4..8), mapped at offsets 0x18 + 4*i.
- BASE_HI, 10'h189, value AA[25:16] must equal for a register hit.
- HIRQ_RST, 16'h0001, reset value of HIRQ (CMOK set).
- TIMEOUT_CYC, 0, CE_R cycles to wait in WAIT_RESP before timing out; 0 disables the timeout.

Ports:
- CLK in 1: system clock.
- RST in 1: reset, synchronous, active-high.
- CE_R in 1: clock enable; all state advances only when CE_R=1.
- AA in 26: A-bus address.
- ADO in 16: host write data, already lane-selected by the top level.
- ADI out 16: read data, combinational.
- ACS2_N in 1: chip select, active low.
- AWRL_N in 1: low-byte write strobe, active low.
- AWRU_N in 1: high-byte write strobe, active low.
- AIRQ_N out 1: registered interrupt request, active low.
- HIRQ_SET in 16: CD-core event bits, ORed into HIRQ every CE_R cycle.
- CMD_VALID out 1: command available.
- CMD_READY in 1: CD core accepts the command.
- CMD_DATA out NUM_CR*16: command snapshot; CR0 in the LSBs.
- RESP_VALID in 1: response present, one CE_R pulse.
- RESP_DATA in NUM_CR*16: response words.
- RESP_HIRQ in 16: extra HIRQ bits set together with the response.
- BUSY out 1: state is not IDLE.
- TIMEOUT out 1: sticky timeout flag; cleared only by RST.

Behaviour:
- Hit: ACS2_N=0 and AA[25:16]=BASE_HI. Offset = {AA[15:1],1'b0}.
- Write event: fires on the first CE_R cycle where hit and (AWRL_N=0 or AWRU_N=0) while the registered previous strobe state was inactive. A held strobe writes once only. Strobe history is updated on every CE_R cycle.
- Lane mask: bits [15:8] enabled by AWRU_N=0, bits [7:0] by AWRL_N=0. Disabled lanes keep their old value.
- Offset 0x08, HIRQ write: on enabled lanes HIRQ <= HIRQ & ADO; disabled lanes are treated as all ones.
- Offset 0x0C, HIRQMASK write: plain lane-masked write.
- CR writes: take effect only in IDLE; in CMD or WAIT_RESP they are silently dropped. Offsets outside the map: writes ignored.
- Reads: 0x08 returns HIRQ, 0x0C returns HIRQMASK, 0x18+4*i returns CR[i]. Any other offset, or no hit, returns 16'h0000.
- Set priority: the next-state HIRQ is (HIRQ after host AND-write) | HIRQ_SET | response/timeout bits. A set always wins over a same-cycle clear.
- FSM (states IDLE, CMD, WAIT_RESP):
  - IDLE → CMD: on a write event to CR[NUM_CR-1]. That word is written first; CMD_DATA captures all CRs including the new word. HIRQ[0] (CMOK) is cleared in the same cycle unless HIRQ_SET[0]=1.
  - CMD: CMD_VALID=1, CMD_DATA held stable. On CE_R with CMD_READY=1 → WAIT_RESP and CMD_VALID drops the same cycle.
  - WAIT_RESP, response: on RESP_VALID, CR[i] <= RESP_DATA[i], HIRQ |= RESP_HIRQ | 16'h0001, → IDLE.
  - WAIT_RESP, timeout: if TIMEOUT_CYC≠0 and the wait counter reaches TIMEOUT_CYC-1 with no RESP_VALID, all CR <= 16'hFFFF, HIRQ[0] set, TIMEOUT=1, → IDLE.
  - RESP_VALID in the same cycle as the timeout: the response wins and TIMEOUT is not set.
  - RESP_VALID outside WAIT_RESP is ignored.
- Wait counter: width $clog2(TIMEOUT_CYC+1); cleared on entry to WAIT_RESP; saturating.
- AIRQ_N: registered ~|(HIRQ & HIRQMASK) computed from current register values; one CE_R cycle of latency after HIRQ/HIRQMASK change.
- Reset values: HIRQ=HIRQ_RST, HIRQMASK=0, CR[0..3]="CDBLOCK" signature 0043/4442/4C4F/434B, CR[4..] = 16'hFFFF, state IDLE, CMD_VALID=0, CMD_DATA=0, BUSY=0, TIMEOUT=0, AIRQ_N=1, strobe history inactive.
- Reset mid-command drops the command; no CMD_VALID on the following cycle.

Decomposition:
- Package cd_host_pkg: state enum (IDLE/CMD/WAIT_RESP), offset constants (HIRQ 0x08, HIRQMASK 0x0C, CR_BASE 0x18), CMOK bit index 0, CR reset signature array.
- Sub-module cd_host_cmd_fsm: state, wait counter, CMD handshake and TIMEOUT. The register file and read mux stay in the parent.

Test Plan:
- Reset → read 0x18..0x24 returns 0043/4442/4C4F/434B; HIRQ=0001; AIRQ_N=1.
- Write HIRQMASK=0001, hold AWRL/AWRU low for 5 CE_R cycles → one write event; AIRQ_N=0 one CE_R cycle later.
- Write CR0..CR3 = 1111/2222/3333/4444 → CMD_VALID=1, CMD_DATA=4444_3333_2222_1111, HIRQ[0]=0, BUSY=1. Write CR0=FFFF during CMD → ignored. Hold CMD_READY low 3 cycles, then high → WAIT_RESP.
- RESP_VALID with RESP_DATA=A..D and RESP_HIRQ=0040 → CRs read A/B/C/D, HIRQ=0041, BUSY=0.
- Same-cycle host HIRQ write 0000 and HIRQ_SET=0004 → HIRQ=0004.
- TIMEOUT_CYC=8, no response → exactly 8 CE_R cycles in WAIT_RESP, then CRs=FFFF, TIMEOUT=1, HIRQ[0]=1. Assert RST mid-CMD → all outputs return to reset values.

Source files
------------

// File: rtl/cd_host_pkg.sv
// Shared types and constants for the CD block host register interface.
// Holds the command FSM state, the register offset map and the CR reset signature.
package cd_host_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CMD       = 2'd1,
    ST_WAIT_RESP = 2'd2
  } cd_state_e;

  localparam logic [15:0] OFF_HIRQ     = 16'h0008;
  localparam logic [15:0] OFF_HIRQMASK = 16'h000C;
  localparam logic [15:0] OFF_CR_BASE  = 16'h0018;

  localparam int          CMOK_BIT  = 0;
  localparam logic [15:0] CMOK_MASK = 16'h0001;

  // "CDBLOCK" signature in CR0..CR3; any further CRs come up as all ones.
  function automatic logic [15:0] cr_rst_val(input int idx);
    case (idx)
      0:       return 16'h0043;
      1:       return 16'h4442;
      2:       return 16'h4C4F;
      3:       return 16'h434B;
      default: return 16'hFFFF;
    endcase
  endfunction

  function automatic logic [15:0] cr_offset(input int idx);
    return OFF_CR_BASE + 16'(4 * idx);
  endfunction

endpackage

// File: rtl/cd_host_if_if.sv
// SCU A-bus chip-select 2 signals seen by the CD host register block.
// The host side drives address, data and strobes; the block returns read data.
interface cd_host_if_if;
  logic [25:0] AA;
  logic [15:0] ADO;
  logic [15:0] ADI;
  logic        ACS2_N;
  logic        AWRL_N;
  logic        AWRU_N;

  modport master (
    output AA, ADO, ACS2_N, AWRL_N, AWRU_N,
    input  ADI
  );

  modport slave (
    input  AA, ADO, ACS2_N, AWRL_N, AWRU_N,
    output ADI
  );
endinterface

// File: rtl/cd_host_cmd_fsm.sv
// Command handshake sequencer: IDLE -> CMD -> WAIT_RESP, with optional response timeout.
// Emits single-cycle event strobes the register file uses to load CRs and HIRQ.
module cd_host_cmd_fsm
  import cd_host_pkg::*;
#(
  parameter int TIMEOUT_CYC = 0
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      CE_R,
  input  logic      i_start,
  input  logic      i_cmd_ready,
  input  logic      i_resp_valid,
  output cd_state_e o_state,
  output logic      o_start_take,
  output logic      o_resp_take,
  output logic      o_timeout_fire,
  output logic      o_cmd_valid,
  output logic      o_busy,
  output logic      o_timeout
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  cd_state_e        r_state;
  cd_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout;
  logic             w_start_take;
  logic             w_resp_take;
  logic             w_timeout_fire;

  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so no path
    // leaves a variable unassigned and no latch is inferred.
    w_state_nxt    = r_state;
    w_start_take   = 1'b0;
    w_resp_take    = 1'b0;
    w_timeout_fire = 1'b0;
    if (CE_R) begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_start_take = 1'b1;
            w_state_nxt  = ST_CMD;
          end
        end
        ST_CMD: begin
          if (i_cmd_ready) w_state_nxt = ST_WAIT_RESP;
        end
        ST_WAIT_RESP: begin
          // A response arriving on the timeout cycle takes precedence.
          if (i_resp_valid) begin
            w_resp_take = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if ((TIMEOUT_CYC != 0) && (r_wait_cnt == CNT_LAST)) begin
            w_timeout_fire = 1'b1;
            w_state_nxt    = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses '<=' so every flop samples pre-edge values,
  // independent of statement order inside the block.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (CE_R) begin
      r_state <= w_state_nxt;
      // Held at zero outside WAIT_RESP, so it always starts from zero on entry.
      if (r_state != ST_WAIT_RESP) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != '1) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_timeout_fire) r_timeout <= 1'b1;
    end
  end

  assign o_state        = r_state;
  assign o_start_take   = w_start_take;
  assign o_resp_take    = w_resp_take;
  assign o_timeout_fire = w_timeout_fire;
  assign o_cmd_valid    = (r_state == ST_CMD);
  assign o_busy         = (r_state != ST_IDLE);
  assign o_timeout      = r_timeout;

endmodule

// File: rtl/cd_host_if.sv
// CD block host register file on A-bus CS2: HIRQ, HIRQMASK and the CR command/response
// words, with write-edge detection, read mux and registered interrupt output.
module cd_host_if
  import cd_host_pkg::*;
#(
  parameter int          NUM_CR      = 4,
  parameter logic [9:0]  BASE_HI     = 10'h189,
  parameter logic [15:0] HIRQ_RST    = 16'h0001,
  parameter int          TIMEOUT_CYC = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE_R,
  cd_host_if_if.slave           abus,
  output logic                  AIRQ_N,
  input  logic [15:0]           HIRQ_SET,
  output logic                  CMD_VALID,
  input  logic                  CMD_READY,
  output logic [NUM_CR*16-1:0]  CMD_DATA,
  input  logic                  RESP_VALID,
  input  logic [NUM_CR*16-1:0]  RESP_DATA,
  input  logic [15:0]           RESP_HIRQ,
  output logic                  BUSY,
  output logic                  TIMEOUT
);

  logic                 w_hit;
  logic [15:0]          w_offset;
  logic [15:0]          w_lane_mask;
  logic                 w_strb;
  logic                 r_strb_prev;
  logic                 w_wr_ev;
  logic                 w_last_cr_wr;
  logic                 w_unused_aa0;

  logic [15:0]          r_hirq;
  logic [15:0]          r_hirqmask;
  logic [15:0]          r_cr [NUM_CR];
  logic [NUM_CR*16-1:0] r_cmd_data;
  logic                 r_airq_n;

  logic [15:0]          w_hirq_nxt;
  logic [15:0]          w_hirqmask_nxt;
  logic [15:0]          w_cr_nxt [NUM_CR];
  logic [NUM_CR*16-1:0] w_cr_nxt_flat;
  logic [15:0]          w_rdata;

  cd_state_e            w_state;
  logic                 w_start_take;
  logic                 w_resp_take;
  logic                 w_timeout_fire;

  assign w_hit        = ~abus.ACS2_N && (abus.AA[25:16] == BASE_HI);
  assign w_offset     = {abus.AA[15:1], 1'b0};
  assign w_unused_aa0 = abus.AA[0];
  assign w_lane_mask  = {{8{~abus.AWRU_N}}, {8{~abus.AWRL_N}}};
  assign w_strb       = ~abus.AWRL_N | ~abus.AWRU_N;
  // Only the leading edge of a strobe writes; a held strobe is a single access.
  assign w_wr_ev      = CE_R & w_hit & w_strb & ~r_strb_prev;
  assign w_last_cr_wr = w_wr_ev && (w_offset == cr_offset(NUM_CR - 1));

  cd_host_cmd_fsm #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_cmd_fsm (
    .CLK            (CLK),
    .RST            (RST),
    .CE_R           (CE_R),
    .i_start        (w_last_cr_wr),
    .i_cmd_ready    (CMD_READY),
    .i_resp_valid   (RESP_VALID),
    .o_state        (w_state),
    .o_start_take   (w_start_take),
    .o_resp_take    (w_resp_take),
    .o_timeout_fire (w_timeout_fire),
    .o_cmd_valid    (CMD_VALID),
    .o_busy         (BUSY),
    .o_timeout      (TIMEOUT)
  );

  always_comb begin
    for (int i = 0; i < NUM_CR; i++) begin
      w_cr_nxt[i] = r_cr[i];
      if ((w_state == ST_IDLE) && w_wr_ev && (w_offset == cr_offset(i))) begin
        w_cr_nxt[i] = (r_cr[i] & ~w_lane_mask) | (abus.ADO & w_lane_mask);
      end
      if (w_resp_take)    w_cr_nxt[i] = RESP_DATA[i*16 +: 16];
      if (w_timeout_fire) w_cr_nxt[i] = 16'hFFFF;
      w_cr_nxt_flat[i*16 +: 16] = w_cr_nxt[i];
    end
  end

  always_comb begin
    // NOTE: blocking '=' in combinational logic; later statements override earlier
    // ones, so the statement order below is the set-over-clear priority.
    w_hirq_nxt = r_hirq;
    if (w_wr_ev && (w_offset == OFF_HIRQ)) begin
      w_hirq_nxt = r_hirq & (abus.ADO | ~w_lane_mask);
    end
    if (w_start_take) w_hirq_nxt[CMOK_BIT] = 1'b0;
    w_hirq_nxt = w_hirq_nxt | HIRQ_SET;
    if (w_resp_take)    w_hirq_nxt = w_hirq_nxt | RESP_HIRQ | CMOK_MASK;
    if (w_timeout_fire) w_hirq_nxt = w_hirq_nxt | CMOK_MASK;

    w_hirqmask_nxt = r_hirqmask;
    if (w_wr_ev && (w_offset == OFF_HIRQMASK)) begin
      w_hirqmask_nxt = (r_hirqmask & ~w_lane_mask) | (abus.ADO & w_lane_mask);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_strb_prev <= 1'b0;
      r_hirq      <= HIRQ_RST;
      r_hirqmask  <= 16'h0000;
      r_cmd_data  <= '0;
      r_airq_n    <= 1'b1;
      // NOTE: the CR array is explicitly reset because the host reads the
      // signature straight after reset; it is flops, not a RAM macro.
      for (int i = 0; i < NUM_CR; i++) r_cr[i] <= cr_rst_val(i);
    end else if (CE_R) begin
      r_strb_prev <= w_strb;
      r_hirq      <= w_hirq_nxt;
      r_hirqmask  <= w_hirqmask_nxt;
      r_airq_n    <= ~|(r_hirq & r_hirqmask);
      for (int i = 0; i < NUM_CR; i++) r_cr[i] <= w_cr_nxt[i];
      if (w_start_take) r_cmd_data <= w_cr_nxt_flat;
    end
  end

  always_comb begin
    w_rdata = 16'h0000;
    if (w_hit) begin
      if (w_offset == OFF_HIRQ)     w_rdata = r_hirq;
      if (w_offset == OFF_HIRQMASK) w_rdata = r_hirqmask;
      for (int i = 0; i < NUM_CR; i++) begin
        if (w_offset == cr_offset(i)) w_rdata = r_cr[i];
      end
    end
  end

  assign abus.ADI = w_rdata;
  assign AIRQ_N   = r_airq_n;
  assign CMD_DATA = r_cmd_data;

endmodule
